// File: rtl/addr4u_seq_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
// Holds the FSM state encoding, the adder slice width and an index-width helper.
package addr4u_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NIB_W = 4;

  // Width needed to index v items; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/addr4u_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer register itself lives in the parent.
module addr4u_rr_arb
  import addr4u_seq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int j;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        idx = ID_W'(j);
        any = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = any && (idx == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/addr4u_seq_ctrl.sv
// Arbitrates NREQ requesters onto one external 4-bit adder and runs each
// (4*NIB)-bit add nibble by nibble, with an extra +1 pass for carried nibbles.
module addr4u_seq_ctrl
  import addr4u_seq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NIB  = 4,
  localparam int W    = NIB_W * NIB,
  localparam int ID_W = clog2(NREQ),
  localparam int K_W  = clog2(NIB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W:0]        rsp_sum,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  input  logic [4:0]        add_o
);

  state_t          state_reg, state_next;
  logic [ID_W-1:0] ptr_reg, ptr_next;
  logic [ID_W-1:0] id_reg, id_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic [W-1:0]    s_reg, s_next;
  logic            carry_reg, carry_next;
  logic [K_W-1:0]  k_reg, k_next;
  logic [NREQ-1:0] ready_next;

  logic [NREQ-1:0] arb_grant;
  logic [ID_W-1:0] arb_idx;
  logic            arb_any;
  logic            last_nib;

  addr4u_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign last_nib = (k_reg == K_W'(NIB - 1));

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    s_next     = s_reg;
    carry_next = carry_reg;
    k_next     = k_reg;
    ready_next = '0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          ready_next = arb_grant;
          a_next     = req_a[arb_idx*W +: W];
          b_next     = req_b[arb_idx*W +: W];
          id_next    = arb_idx;
          ptr_next   = (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          s_next     = '0;
          carry_next = 1'b0;
          k_next     = '0;
          state_next = ADD;
        end
      end
      ADD: begin
        add_a = a_reg[k_reg*NIB_W +: NIB_W];
        add_b = b_reg[k_reg*NIB_W +: NIB_W];
        s_next[k_reg*NIB_W +: NIB_W] = add_o[3:0];
        carry_next = add_o[4];
        // An incoming carry means this nibble still owes a +1 pass.
        if (carry_reg) begin
          state_next = INC;
        end else if (last_nib) begin
          state_next = DONE;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      INC: begin
        add_a = s_reg[k_reg*NIB_W +: NIB_W];
        add_b = 4'b0001;
        s_next[k_reg*NIB_W +: NIB_W] = add_o[3:0];
        carry_next = carry_reg | add_o[4];
        if (last_nib) begin
          state_next = DONE;
        end else begin
          k_next     = k_reg + 1'b1;
          state_next = ADD;
        end
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      s_reg     <= s_next;
      carry_reg <= carry_next;
      k_reg     <= k_next;
    end
  end

  assign req_ready = rst ? '0 : ready_next;
  assign rsp_valid = (state_reg == DONE);
  assign rsp_id    = id_reg;
  assign rsp_sum   = {carry_reg, s_reg};

endmodule

// File: tb/tb_addr4u_seq_ctrl.sv
// Directed bench for addr4u_seq_ctrl with NREQ=4, NIB=4 and an ideal adder model.
module tb_addr4u_seq_ctrl;

  localparam int NREQ = 4;
  localparam int NIB  = 4;
  localparam int W    = 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W:0]        rsp_sum;
  logic [3:0]        add_a;
  logic [3:0]        add_b;
  logic [4:0]        add_o;

  int checks = 0;
  int errors = 0;

  addr4u_seq_ctrl #(.NREQ(NREQ), .NIB(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_o     (add_o)
  );

  assign add_o = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until rsp_valid, counting cycles after the accept cycle; -1 on timeout.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 17'h0 ||
        add_a !== 4'h0 || add_b !== 4'h0 || req_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: valid=%b id=%0d sum=%h a=%h b=%h rdy=%b, required all zero",
               rsp_valid, rsp_id, rsp_sum, add_a, add_b, req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (req_ready !== 4'h0 || rsp_valid !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0) begin
        errors++;
        $display("FAIL idle_quiet cyc %0d: rdy=%b valid=%b a=%h b=%h, required 0", i, req_ready, rsp_valid, add_a, add_b);
      end
    end
    $display("txn reset: idle 10 cycles");
  endtask

  task automatic test_single();
    int lat;
    req_a[0*W +: W] = 16'h1234; req_b[0*W +: W] = 16'h4321;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: req_ready=%b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (add_a !== 4'h4 || add_b !== 4'h1) begin
      errors++;
      $display("FAIL single_nib0: add_a=%h add_b=%h required 4/1", add_a, add_b);
    end
    wait_rsp(1, lat);
    checks++;
    if (lat !== 5 || rsp_sum !== 17'h05555 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp: lat=%0d sum=%h id=%0d required 5/05555/0", lat, rsp_sum, rsp_id);
    end
    $display("txn single: id=%0d sum=%h lat=%0d", rsp_id, rsp_sum, lat);
    take_rsp();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_carry();
    int lat;
    logic inc_seen;
    inc_seen = 1'b0;
    req_a[2*W +: W] = 16'hFFFF; req_b[2*W +: W] = 16'h0001;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL carry_grant: req_ready=%b required 0100", req_ready);
    end
    tick();
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (lat == 3 && add_a == 4'hF && add_b == 4'h1) inc_seen = 1'b1;
      tick();
      lat++;
    end
    checks++;
    if (!inc_seen) begin
      errors++;
      $display("FAIL carry_inc_pass: cycle 3 not an INC of F+1 (seen %b), required 1", inc_seen);
    end
    checks++;
    if (!rsp_valid || lat !== 8 || rsp_sum !== 17'h10000 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL carry_rsp: lat=%0d sum=%h id=%0d required 8/10000/2", lat, rsp_sum, rsp_id);
    end
    $display("txn carry: id=%0d sum=%h lat=%0d", rsp_id, rsp_sum, lat);
    take_rsp();
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    logic [W:0] exp_sum [4];
    int grants, resps, cyc;
    exp_order = '{0, 1, 2, 3, 0};
    exp_sum = '{17'h01212, 17'h02323, 17'h03434, 17'h04545};
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req_b = {16'h0101, 16'h0101, 16'h0101, 16'h0101};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    grants = 0; resps = 0; cyc = 0;
    #1;
    while (resps < 5 && cyc < 150) begin
      if (req_ready !== 4'b0000) begin
        checks++;
        if (grants >= 5 || req_ready !== (4'b0001 << exp_order[grants])) begin
          errors++;
          $display("FAIL rr_grant %0d: req_ready=%b required onehot %0d", grants, req_ready,
                   (grants < 5) ? exp_order[grants] : -1);
        end
        $display("txn rr grant: req_ready=%b", req_ready);
        grants++;
      end
      if (rsp_valid) begin
        checks++;
        if (resps >= 5 || rsp_id !== 2'(exp_order[resps]) || rsp_sum !== exp_sum[rsp_id]) begin
          errors++;
          $display("FAIL rr_rsp %0d: id=%0d sum=%h required id %0d", resps, rsp_id, rsp_sum,
                   (resps < 5) ? exp_order[resps] : -1);
        end
        $display("txn rr rsp: id=%0d sum=%h", rsp_id, rsp_sum);
        resps++;
      end
      tick();
      cyc++;
      if (grants >= 5) req_valid = '0;
    end
    rsp_ready = 1'b0;
    checks++;
    if (grants !== 5 || resps !== 5) begin
      errors++;
      $display("FAIL rr_count: grants=%0d resps=%0d required 5/5", grants, resps);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    req_a[1*W +: W] = 16'hABCD; req_b[1*W +: W] = 16'h1234;
    req_a[3*W +: W] = 16'h0001; req_b[3*W +: W] = 16'h0002;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant: req_ready=%b required 0010", req_ready);
    end
    tick();
    req_valid = 4'b1000;
    wait_rsp(1, lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL bp_latency: lat=%0d required 7", lat);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 17'h0BE01 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold cyc %0d: valid=%b sum=%h id=%0d rdy=%b required 1/0BE01/1/0000",
                 i, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      tick();
    end
    $display("txn backpressure: id=%0d sum=%h", rsp_id, rsp_sum);
    take_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next_grant: valid=%b rdy=%b required 0/1000", rsp_valid, req_ready);
    end
    tick();
    req_valid = '0;
    wait_rsp(1, lat);
    checks++;
    if (lat !== 5 || rsp_sum !== 17'h00003 || rsp_id !== 2'd3) begin
      errors++;
      $display("FAIL bp_second_rsp: lat=%0d sum=%h id=%0d required 5/00003/3", lat, rsp_sum, rsp_id);
    end
    $display("txn backpressure follow-up: id=%0d sum=%h", rsp_id, rsp_sum);
    take_rsp();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    req_a[0*W +: W] = 16'h1234; req_b[0*W +: W] = 16'h4321;
    req_a[1*W +: W] = 16'h0F00; req_b[1*W +: W] = 16'h0100;
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    tick(); tick();
    checks++;
    if (add_a !== 4'h2 || add_b !== 4'h3) begin
      errors++;
      $display("FAIL mid_nib2: add_a=%h add_b=%h required 2/3", add_a, add_b);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 17'h0 ||
        add_a !== 4'h0 || add_b !== 4'h0 || req_ready !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset_values: valid=%b id=%0d sum=%h a=%h b=%h rdy=%b required all zero",
               rsp_valid, rsp_id, rsp_sum, add_a, add_b, req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_no_rsp: rsp_valid seen=%b required 0", seen);
    end
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ptr_zero: req_ready=%b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    wait_rsp(1, lat);
    checks++;
    if (lat !== 5 || rsp_sum !== 17'h05555 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_after_rsp: lat=%0d sum=%h id=%0d required 5/05555/0", lat, rsp_sum, rsp_id);
    end
    $display("txn after mid reset: id=%0d sum=%h", rsp_id, rsp_sum);
    take_rsp();
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
